// File: rtl/dytr_user_seq.sv
// dytr_user_seq -- user-side sequencer for the DyTR3 dynamic time-redundancy core.
//
// Accepts one work token per upstream handshake, strobes userFetch to the core,
// waits LAT cycles for the core's registered userFail, then either completes the
// token, retries it in triple-time-redundancy mode (userMode=1), or raises a
// sticky alarm after RETRY_MAX consecutive failures on the same token. After
// CLEAN_TH consecutive clean tokens in mode 1 the sequencer drops back to mode 0.
//
// Parameters:
//   LAT       cycles from the userFetch pulse to the cycle in which userFail is final (>=1)
//   RETRY_MAX consecutive failed attempts on one token before alarm (>=1)
//   CLEAN_TH  consecutive clean tokens in mode 1 before returning to mode 0 (>=1)
//   CNT_W     width of the latency/retry/clean counters
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_valid   upstream token available
//   in_ready   sequencer accepts a token (IDLE)
//   userMode   0 = normal, 1 = triple time redundancy
//   userFetch  one-cycle fetch strobe to the core
//   userFail   registered fail flag from the core, sampled only in WAIT
//   out_valid  current token completed without failure, held until out_ack
//   out_ack    downstream consumed the completion
//   alarm      sticky unrecoverable-failure flag, cleared only by reset
//   err_cnt    saturating failure counter
//
// Build option:
//   DYTR_USER_FAILCNT_EN  when defined, err_cnt counts failed decisions
//                         (saturating at 255); otherwise err_cnt is tied to 0.
//
// All outputs are registers loaded from the next-state decode, so they track the
// state register exactly and have no combinational path from any input.

module dytr_user_seq #(
  parameter int LAT       = 3,
  parameter int RETRY_MAX = 3,
  parameter int CLEAN_TH  = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       userMode,
  output logic       userFetch,
  input  logic       userFail,
  output logic       out_valid,
  input  logic       out_ack,
  output logic       alarm,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LatLoad   = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] RetryLast = CNT_W'(RETRY_MAX - 1);
  localparam logic [CNT_W-1:0] CleanLast = CNT_W'(CLEAN_TH - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] latCnt;
  logic [CNT_W-1:0] retryCnt;
  logic [CNT_W-1:0] cleanCnt;
  logic             failLatch;
  logic             decide;
  logic             failNow;

  // Decision happens on the last WAIT cycle; a fail pulse seen earlier in the
  // window is remembered in failLatch.
  assign decide  = (state == WAIT) && (latCnt == '0);
  assign failNow = failLatch | userFail;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        // in_ready gates acceptance so no token is taken in the cycle right
        // after reset, where in_ready is still low.
        if (in_valid && in_ready) stateNext = FETCH;
      end
      FETCH: stateNext = WAIT;
      WAIT: begin
        if (decide) begin
          if (failNow) stateNext = (retryCnt == RetryLast) ? ALARM : FETCH;
          else         stateNext = DONE;
        end
      end
      DONE: begin
        if (out_ack) stateNext = IDLE;
      end
      ALARM: stateNext = ALARM;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      latCnt    <= '0;
      retryCnt  <= '0;
      cleanCnt  <= '0;
      failLatch <= 1'b0;
      userMode  <= 1'b0;
      in_ready  <= 1'b0;
      userFetch <= 1'b0;
      out_valid <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= stateNext;
      in_ready  <= (stateNext == IDLE);
      userFetch <= (stateNext == FETCH);
      out_valid <= (stateNext == DONE);
      alarm     <= (stateNext == ALARM);

      case (state)
        FETCH: begin
          latCnt    <= LatLoad;
          failLatch <= 1'b0;
        end
        WAIT: begin
          if (userFail) failLatch <= 1'b1;
          if (latCnt != '0) begin
            latCnt <= latCnt - 1'b1;
          end else if (failNow) begin
            // Any failure escalates to TTR mode; this also covers the path
            // into ALARM, where the mode must read 1.
            userMode <= 1'b1;
            cleanCnt <= '0;
            if (retryCnt != RetryLast) retryCnt <= retryCnt + 1'b1;
          end else begin
            retryCnt <= '0;
            if (userMode) begin
              if (cleanCnt == CleanLast) begin
                userMode <= 1'b0;
                cleanCnt <= '0;
              end else begin
                cleanCnt <= cleanCnt + 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DYTR_USER_FAILCNT_EN
  logic [7:0] errCnt;
  logic       failDecision;

  assign failDecision = decide && failNow;

  always_ff @(posedge clk) begin
    if (reset) begin
      errCnt <= 8'd0;
    end else if (failDecision && (errCnt != 8'hFF)) begin
      errCnt <= errCnt + 8'd1;
    end
  end

  assign err_cnt = errCnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dytr_user_seq.sv
// Directed bench for dytr_user_seq with default parameters (LAT=3, RETRY_MAX=3,
// CLEAN_TH=8). Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_dytr_user_seq;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       userMode;
  logic       userFetch;
  logic       userFail;
  logic       out_valid;
  logic       out_ack;
  logic       alarm;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

`ifdef DYTR_USER_FAILCNT_EN
  localparam bit FailCntEn = 1'b1;
`else
  localparam bit FailCntEn = 1'b0;
`endif

  dytr_user_seq #(.LAT(3), .RETRY_MAX(3), .CLEAN_TH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .userMode  (userMode),
    .userFetch (userFetch),
    .userFail  (userFail),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .alarm     (alarm),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected err_cnt for a given number of failed decisions since reset.
  function automatic int expErr(input int nFails);
    if (!FailCntEn) return 0;
    return (nFails > 255) ? 255 : nFails;
  endfunction

  // Drives one token; userFail is pulsed in the first WAIT cycle of each of the
  // first nFail attempts. Acknowledges the completion and returns to IDLE.
  task automatic run_token(input int nFail, output int fetches, output bit got,
                           output int doneAt, output bit modeAtLastFetch,
                           output bit modeAtDone);
    bit failNext;
    fetches = 0; got = 1'b0; doneAt = -1; failNext = 1'b0;
    modeAtLastFetch = 1'b0; modeAtDone = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      tick();
      in_valid = 1'b0;
      userFail = failNext;
      failNext = 1'b0;
      if (userFetch) begin
        fetches++;
        modeAtLastFetch = userMode;
        if (fetches <= nFail) failNext = 1'b1;
      end
      if (out_valid) begin
        got = 1'b1;
        doneAt = c + 1;
        modeAtDone = userMode;
      end
    end
    userFail = 1'b0;
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; userFail = 1'b0; out_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({in_ready, userMode, userFetch, out_valid, alarm} !== 5'b0 || err_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b mode=%b fetch=%b ov=%b alarm=%b err=%0d required all 0",
                 i, in_ready, userMode, userFetch, out_valid, alarm, err_cnt);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || userMode !== 1'b0 || userFetch !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b mode=%b fetch=%b required rdy=1 mode=0 fetch=0",
               in_ready, userMode, userFetch);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_token();
    int extraFetch = 0;
    in_valid = 1'b1;                       // token at cycle t
    tick();                                // t+1
    checks++;
    if (userFetch !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_fetch_t1: got fetch=%b rdy=%b required fetch=1 rdy=0", userFetch, in_ready);
    end
    in_valid = 1'b0;
    userFail = 1'b1;                       // high during FETCH only: must be ignored
    tick();                                // t+2
    checks++;
    if (userFetch !== 1'b0) begin
      errors++;
      $display("FAIL clean_fetch_t2: got fetch=%b required 0", userFetch);
    end
    userFail = 1'b0;
    out_ack = 1'b1;                        // ack outside DONE: ignored
    tick();                                // t+3
    out_ack = 1'b0;
    if (userFetch) extraFetch++;
    tick();                                // t+4 decision
    if (userFetch) extraFetch++;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_ov_early: got out_valid=%b at t+4 required 0", out_valid);
    end
    tick();                                // t+5
    checks++;
    if (out_valid !== 1'b1 || userMode !== 1'b0) begin
      errors++;
      $display("FAIL clean_ov_t5: got out_valid=%b mode=%b required out_valid=1 mode=0", out_valid, userMode);
    end
    tick();                                // t+6
    if (userFetch) extraFetch++;
    tick();                                // t+7
    if (userFetch) extraFetch++;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clean_ov_hold: got out_valid=%b at t+7 required 1", out_valid);
    end
    out_ack = 1'b1;
    tick();                                // t+8
    out_ack = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || extraFetch != 0) begin
      errors++;
      $display("FAIL clean_idle_t8: got rdy=%b ov=%b extra_fetch=%0d required rdy=1 ov=0 extra_fetch=0",
               in_ready, out_valid, extraFetch);
    end
    $display("test_clean_token done");
  endtask

  task automatic test_single_fail();
    int fetches, doneAt;
    bit got, mf, md;
    run_token(1, fetches, got, doneAt, mf, md);
    checks++;
    if (!got || fetches != 2 || doneAt != 2 + LAT + 1 + LAT) begin
      errors++;
      $display("FAIL single_fail_flow: got done=%b fetches=%0d done_at=%0d required done=1 fetches=2 done_at=%0d",
               got, fetches, doneAt, 2 + 2 * LAT + 1);
    end
    checks++;
    if (mf !== 1'b1 || md !== 1'b1) begin
      errors++;
      $display("FAIL single_fail_mode: got mode_at_refetch=%b mode_at_done=%b required 1 1", mf, md);
    end
    checks++;
    if (err_cnt !== 8'(expErr(1))) begin
      errors++;
      $display("FAIL single_fail_err: got err_cnt=%0d required %0d", err_cnt, expErr(1));
    end
    $display("test_single_fail done");
  endtask

  // One clean token in mode 1 has already completed (the single-fail retry).
  task automatic test_mode_recovery();
    int fetches, doneAt;
    bit got, mf, md;
    int badEarly = 0;
    for (int k = 2; k <= 7; k++) begin
      run_token(0, fetches, got, doneAt, mf, md);
      if (!got || md !== 1'b1) badEarly++;
    end
    checks++;
    if (badEarly != 0) begin
      errors++;
      $display("FAIL recovery_tokens_2to7: got %0d tokens with mode!=1 or no completion required 0", badEarly);
    end
    run_token(0, fetches, got, doneAt, mf, md);
    checks++;
    if (!got || mf !== 1'b1 || md !== 1'b0 || userMode !== 1'b0) begin
      errors++;
      $display("FAIL recovery_token8: got done=%b mode_at_fetch=%b mode_at_done=%b required 1 1 0",
               got, mf, md);
    end
    $display("test_mode_recovery done");
  endtask

  task automatic test_alarm();
    int fetches = 0;
    int ovSeen = 0;
    bit hit = 1'b0;
    userFail = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && !hit; c++) begin
      tick();
      in_valid = 1'b0;
      if (userFetch) fetches++;
      if (out_valid) ovSeen++;
      if (alarm) hit = 1'b1;
    end
    checks++;
    if (!hit || fetches != 3 || ovSeen != 0) begin
      errors++;
      $display("FAIL alarm_entry: got alarm=%b fetches=%0d ov=%0d required alarm=1 fetches=3 ov=0",
               hit, fetches, ovSeen);
    end
    checks++;
    if (userMode !== 1'b1 || in_ready !== 1'b0 || err_cnt !== 8'(expErr(4))) begin
      errors++;
      $display("FAIL alarm_outputs: got mode=%b rdy=%b err=%0d required mode=1 rdy=0 err=%0d",
               userMode, in_ready, err_cnt, expErr(4));
    end
    userFail = 1'b0;
    in_valid = 1'b1;
    fetches = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (userFetch || in_ready || out_valid || !alarm || !userMode) fetches++;
    end
    in_valid = 1'b0;
    checks++;
    if (fetches != 0) begin
      errors++;
      $display("FAIL alarm_sticky: got %0d cycles leaving alarm behaviour required 0", fetches);
    end
    $display("test_alarm done");
  endtask

  task automatic test_mid_reset();
    int fetches, doneAt, bad;
    bit got, mf, md;
    apply_reset();
    in_valid = 1'b1;
    tick();                // FETCH 1
    in_valid = 1'b0;
    tick();                // WAIT 1
    userFail = 1'b1;
    tick();                // WAIT 2
    userFail = 1'b0;
    tick();                // WAIT 3, decision: fail
    tick();                // FETCH 2
    checks++;
    if (userFetch !== 1'b1 || userMode !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_refetch: got fetch=%b mode=%b required 1 1", userFetch, userMode);
    end
    tick();                // WAIT of attempt 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid || userFetch) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1 || userMode !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got bad=%0d rdy=%b mode=%b err=%0d required 0 1 0 0",
               bad, in_ready, userMode, err_cnt);
    end
    // Retry count must have cleared: two fails then a pass must still complete.
    run_token(2, fetches, got, doneAt, mf, md);
    checks++;
    if (!got || fetches != 3 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_retry_clear: got done=%b fetches=%0d alarm=%b required 1 3 0",
               got, fetches, alarm);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_saturation();
    int fetches, doneAt, lost;
    bit got, mf, md;
    apply_reset();
    lost = 0;
    for (int k = 0; k < 127; k++) begin
      run_token(2, fetches, got, doneAt, mf, md);
      if (!got) lost++;
    end
    checks++;
    if (err_cnt !== 8'(expErr(254))) begin
      errors++;
      $display("FAIL sat_254: got err_cnt=%0d required %0d", err_cnt, expErr(254));
    end
    for (int k = 127; k < 150; k++) begin
      run_token(2, fetches, got, doneAt, mf, md);
      if (!got) lost++;
    end
    checks++;
    if (err_cnt !== 8'(expErr(300)) || lost != 0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL sat_300: got err_cnt=%0d lost=%0d alarm=%b required err_cnt=%0d lost=0 alarm=0",
               err_cnt, lost, alarm, expErr(300));
    end
    $display("test_saturation done");
  endtask

  task automatic test_back_to_back();
    int f1, f2, nOv;
    f1 = -1; f2 = -1; nOv = 0;
    apply_reset();
    in_valid = 1'b1;
    out_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (userFetch) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
      if (out_valid) nOv++;
    end
    in_valid = 1'b0;
    out_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (f1 < 0 || f2 < 0 || (f2 - f1) != LAT + 3) begin
      errors++;
      $display("FAIL back_to_back_period: got period=%0d required %0d", f2 - f1, LAT + 3);
    end
    checks++;
    if (nOv < 3) begin
      errors++;
      $display("FAIL back_to_back_completions: got %0d out_valid cycles required >=3", nOv);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; userFail = 1'b0; out_ack = 1'b0;
    test_reset();
    test_clean_token();
    test_single_fail();
    test_mode_recovery();
    test_alarm();
    test_mid_reset();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
